// File: rtl/dmem_responder.sv
// Data-memory responder: queues word load/store requests in order, services each after WAIT
// wait states and returns one response per request. Define DMEM_ERR_EN to add rsp_err.
module dmem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 2,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef DMEM_ERR_EN
  output logic              rsp_err,
`endif
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              q_we_q    [QDEPTH];
  logic [ADDR_W-1:0] q_addr_q  [QDEPTH];
  logic [DATA_W-1:0] q_wdata_q [QDEPTH];
  logic              cur_we_q, cur_we_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] cur_wdata_q, cur_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push, pop, addr_oor, mem_wr;
  logic [IDX_W-1:0]  idx;

  assign idx = cur_addr_q[IDX_W-1:0];
`ifdef DMEM_ERR_EN
  assign addr_oor = |(cur_addr_q >> IDX_W);
  assign rsp_err  = rsp_err_q;
`else
  // Upper address bits alias modulo DEPTH in this build.
  logic addr_hi_unused;
  assign addr_hi_unused = |(cur_addr_q >> IDX_W);
  assign addr_oor = 1'b0;
`endif

  assign req_ready = (count_q != FULL_CNT);
  assign push      = req_valid && req_ready;
  assign busy      = (count_q != '0) || (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_wr    = (state_q == S_ACCESS) && cur_we_q && !addr_oor && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: pop = (count_q != '0);
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_we_d    = cur_we_q;
        rsp_err_d   = addr_oor;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          pop         = (count_q != '0);
          if (count_q == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop always starts the next request's wait sequence, with no IDLE bubble.
    if (pop) begin
      state_d = (WAIT == 0) ? S_ACCESS : S_WAIT;
      cnt_d   = WAIT_CNT;
    end
  end

  always_comb begin
    count_d     = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cur_we_d    = pop ? q_we_q[rd_ptr_q]    : cur_we_q;
    cur_addr_d  = pop ? q_addr_q[rd_ptr_q]  : cur_addr_q;
    cur_wdata_d = pop ? q_wdata_q[rd_ptr_q] : cur_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_we_q    <= cur_we_d;
    cur_addr_q  <= cur_addr_d;
    cur_wdata_q <= cur_wdata_d;
    if (push) begin
      q_we_q[wr_ptr_q]    <= req_we;
      q_addr_q[wr_ptr_q]  <= req_addr;
      q_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[idx] <= cur_wdata_q;
  end

  // Registered read port; stores and out-of-range accesses answer with zero.
  always_ff @(posedge clk) begin
    if (rst) rsp_rdata_q <= '0;
    else if (state_q == S_ACCESS) rsp_rdata_q <= (cur_we_q || addr_oor) ? '0 : mem[idx];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder, checked against an in-order
// transaction model (reference memory plus queue of expected responses).
module tb_dmem_responder;
  localparam int DEPTH  = 256;
  localparam int WAIT_C = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [15:0] rsp_rdata;
  logic        busy;
`ifdef DMEM_ERR_EN
  logic        rsp_err;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .WAIT(WAIT_C), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
`ifdef DMEM_ERR_EN
    .rsp_err(rsp_err),
`endif
    .busy(busy)
  );

  typedef struct packed {logic we; logic err; logic [15:0] data;} exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_hs = -1;
  int          n_rsp = 0;
  bit          tp_on = 1'b0;
  bit          hold_prev = 1'b0;
  logic        hold_we;
  logic [15:0] hold_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: starts and ends at a falling edge, models the handshakes of the next rising edge.
  task automatic cycle(input bit rv, input bit we, input logic [15:0] addr,
                       input logic [15:0] data, input bit rr, output bit acc);
    exp_t e;
    bit   oor;
    int   idx;
    cyc++;
    chk("busy", busy, exp_q.size() != 0);
    if (hold_prev) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, hold_data);
      chk("hold_we", rsp_we, hold_we);
    end
    req_valid = rv; req_we = we; req_addr = addr; req_wdata = data; rsp_ready = rr;
    acc = rv && req_ready;
    if (rsp_valid && rr) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        e = exp_q.pop_front();
        n_rsp++;
        $display("rsp %0d: we=%0b rdata=%h expect we=%0b rdata=%h", n_rsp, rsp_we, rsp_rdata, e.we, e.data);
        chk("rsp_we", rsp_we, e.we);
        chk("rsp_rdata", rsp_rdata, e.data);
`ifdef DMEM_ERR_EN
        chk("rsp_err", rsp_err, e.err);
`endif
        if (tp_on) begin
          if (last_hs >= 0) chk("rsp_period", cyc - last_hs, WAIT_C + 2);
          last_hs = cyc;
        end
      end
    end
    hold_prev = rsp_valid && !rr;
    hold_we   = rsp_we;
    hold_data = rsp_rdata;
    if (acc) begin
      oor = 1'b0;
`ifdef DMEM_ERR_EN
      oor = (int'(addr) >= DEPTH);
`endif
      idx = int'(addr) % DEPTH;
      if (we) begin
        if (!oor) ref_mem[idx] = data;
        e = '{we: 1'b1, err: oor, data: 16'h0000};
      end else begin
        e = '{we: 1'b0, err: oor, data: (oor ? 16'h0000 : ref_mem[idx])};
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bit we, input logic [15:0] addr, input logic [15:0] data);
    bit acc = 1'b0;
    int k = 0;
    while (!acc && k < 50) begin
      cycle(1'b1, we, addr, data, 1'b1, acc);
      k++;
    end
    chk("send_accept", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
  endtask

  task automatic drain();
    bit acc;
    int k = 0;
    while ((exp_q.size() != 0 || rsp_valid) && k < 200) begin
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
      k++;
    end
    chk("drain_in_time", k < 200, 1);
  endtask

  task automatic latency(input bit we, input logic [15:0] addr, input logic [15:0] data);
    bit acc;
    int n = 0;
    cycle(1'b1, we, addr, data, 1'b0, acc);
    chk("lat_accept", acc, 1);
    while (!rsp_valid && n < 20) begin
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
      n++;
    end
    chk("latency", n, WAIT_C + 2);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 16'($urandom); req_wdata = 16'($urandom); rsp_ready = ($urandom_range(1) == 1);
    repeat (n) @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
`ifdef DMEM_ERR_EN
    chk("rst_rsp_err", rsp_err, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          sent;
    logic [15:0] d;
    logic [15:0] old3;

    do_reset(2);
    idle(3);

    latency(1'b1, 16'h0005, 16'hBEEF);
    latency(1'b0, 16'h0005, 16'h0000);

    for (int a = 0; a < DEPTH; a++) begin
      d = 16'($urandom);
      if (a == 3 && d == 16'h1234) d = 16'h4321;
      send(1'b1, 16'(a), d);
    end
    drain();

    // Backpressure: three loads offered while the response side is stalled.
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(sent < 3, 1'b0, 16'($urandom_range(255)), 16'h0, 1'b0, acc);
      if (acc) sent++;
    end
    chk("bp_sent", sent, 3);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    tp_on = 1'b1; last_hs = -1;
    drain();
    tp_on = 1'b0;

    // Sustained loads with rsp_ready held high.
    tp_on = 1'b1; last_hs = -1; sent = 0;
    for (int k = 0; k < 100 && (sent < 8 || exp_q.size() != 0); k++) begin
      cycle(sent < 8, 1'b0, 16'($urandom_range(255)), 16'h0, 1'b1, acc);
      if (acc) sent++;
    end
    tp_on = 1'b0;
    chk("tp_sent", sent, 8);
    chk("tp_outstanding", exp_q.size(), 0);

    // Reset while a store sits in its wait states: it must never land.
    old3 = ref_mem[3];
    send(1'b1, 16'h0003, 16'h1234);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
    do_reset(2);
    ref_mem[3] = old3;
    idle(8);
    latency(1'b0, 16'h0003, 16'h0000);

    // Out-of-range store then in-range load of the aliased index.
    send(1'b1, 16'h0105, 16'hA5A5);
    send(1'b0, 16'h0005, 16'h0000);
    drain();

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(99) < 70, ($urandom_range(1) == 1), 16'($urandom_range(511)),
            16'($urandom), $urandom_range(99) < 70, acc);
    end
    drain();
    idle(2);
    chk("final_busy", busy, 0);
    chk("final_rsp_valid", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the CPU's load/store interface.
- Accepts word load/store requests over a valid/ready handshake and buffers them in a small in-order queue.
- Services each request after a configurable number of wait states and returns one response per request over a second valid/ready handshake.
- Used as the data-memory model for the 16-bit pipeline, and as a template for slower memories.

Parameters:
- ADDR_W, 16, request address width in bits
- DATA_W, 16, data word width in bits
- DEPTH, 256, number of words in the array; power of 2
- WAIT, 2, wait-state cycles inserted before each access; legal range 0..15
- QDEPTH, 2, request queue entries; power of 2, at least 2

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_we  output  1  echoes req_we of the request being answered
- rsp_rdata  output  DATA_W  load data; 0 for store responses
- busy  output  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset: the clock and reset are fixed as one clock, clk, with a synchronous active-high reset, rst.
  - On reset: queue emptied, FSM to IDLE, wait counter cleared.
  - On reset: req_ready=1, rsp_valid=0, rsp_we=0, rsp_rdata=0, busy=0.
  - The memory array is not reset.
- Request handshake:
  - A request is accepted on an edge where req_valid && req_ready; it is pushed to the queue tail.
  - req_ready = !queue_full, from the registered count only; there is no combinational path from req_valid.
  - Request fields are sampled only at acceptance.
- Queue:
  - In-order FIFO with wrap-around pointers.
  - A push and a pop on the same edge leave the count unchanged.
  - A push is ignored when full, since req_ready=0.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head. Go to WAIT with cnt=WAIT, or to ACCESS if WAIT=0.
  - WAIT: decrement cnt each cycle. When cnt==1, next state is ACCESS.
  - ACCESS: one cycle. A store writes mem[idx]. A load captures mem[idx] into rsp_rdata; a store sets rsp_rdata=0. Set rsp_valid=1 and rsp_we, then go to RESP.
  - RESP: hold rsp_valid, rsp_we and rsp_rdata stable until rsp_ready. On an edge with rsp_ready, clear rsp_valid. Then either pop the next head directly to WAIT/ACCESS with no IDLE bubble, or return to IDLE if the queue is empty.
- Index rule: idx = req_addr[log2(DEPTH)-1:0].
- Latency: a request accepted at edge E0 into an empty, IDLE responder drives rsp_valid high after edge E(WAIT+2).
  - WAIT=2: 4 cycles after acceptance.
  - WAIT=0: 2 cycles after acceptance.
- Sustained throughput with rsp_ready held high: one response per WAIT+2 cycles.
- Ordering: responses are strictly in request order. A store followed by a load to the same idx returns the new data.
- Reset mid-operation: the in-flight request and all queued requests are dropped. A store whose ACCESS edge has not occurred is never written. No response is emitted for dropped requests.
- busy is asserted the cycle after the first acceptance and deasserts the cycle after the final response handshake with an empty queue.

Optional Feature:
- Macro: DMEM_ERR_EN
- Defined:
  - Adds output port rsp_err (1 bit), reset value 0.
  - A request with req_addr >= DEPTH is out of range.
  - Out of range at ACCESS: no write is performed, rsp_rdata=0, rsp_err=1.
  - rsp_err is valid with rsp_valid and timed identically.
- Not defined:
  - No rsp_err port.
  - Upper address bits are ignored, so addresses alias modulo DEPTH.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with req_valid=1 -> req_ready=1, rsp_valid=0, busy=0, and no request accepted.
- Store then load latency (WAIT=2): store addr 0x0005 data 0xBEEF at E0 -> rsp_valid with rsp_we=1, rsp_rdata=0 after E4. Then load addr 0x0005 -> rsp_rdata=0xBEEF, rsp_we=0, exactly 4 cycles after its acceptance.
- Response backpressure: hold rsp_ready=0 for 10 cycles with 3 loads offered.
  - Required: queue fills and req_ready=0 after 2 pushes beyond the in-flight request.
  - Required: rsp_rdata stays stable while rsp_ready=0.
  - Required: after releasing rsp_ready, responses return in order with no bubble between a pop and the next WAIT.
- Back-to-back throughput (WAIT=0): 8 loads with rsp_ready=1 -> one response every 2 cycles, correct data in order.
- Reset mid-operation: accept store addr 3 data 0x1234, assert rst during WAIT, then load addr 3 -> old value returned, not 0x1234; no stale response emitted.
- Address out of range (DEPTH=256, store to 0x0105):
  - Without DMEM_ERR_EN: load 0x0005 returns the stored data (aliasing).
  - With DMEM_ERR_EN: rsp_err=1, and mem[5] is unchanged.
